conv3x3_stream: RTL
===================

# conv3x3_stream

Streaming 3x3 image convolution engine: it accepts a raster-scan, single-channel pixel stream and produces one filtered pixel per input pixel. It holds two full line buffers, so the window is a true 2-D neighbourhood, and it handles borders explicitly. Both ports use valid/ready handshakes, and a flush phase drains the final row. It sits between the pixel source (camera/frame reader) and the downstream pixel sink in the image pipeline.

## Interface
- PIXEL_WIDTH, 8, bits per unsigned pixel
- IMG_WIDTH, 640, pixels per line (≥ 3)
- IMG_HEIGHT, 480, lines per frame (≥ 2)
- ACC_WIDTH, 16, signed accumulator width (≥ PIXEL_WIDTH+5)
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- mode  in  2  0=sharpen, 1=gaussian blur, 2=edge, 3=pass-through
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_pixel  in  PIXEL_WIDTH  input pixel, unsigned
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_pixel  out  PIXEL_WIDTH  filtered pixel, unsigned, saturated
- m_sof  out  1  marks output pixel (0,0); qualified by m_valid
- m_eol  out  1  marks last pixel of each output line; qualified by m_valid

## Operation
- Kernels (row-major): sharpen [0 -1 0; -1 5 -1; 0 -1 0]; blur [1 2 1; 2 4 2; 1 2 1], then (sum+8)>>>4; edge [-1 -1 -1; -1 8 -1; -1 -1 -1]; pass = centre pixel.
- Pixels are zero-extended to ACC_WIDTH signed. The result saturates to [0, 2^PIXEL_WIDTH-1].
- mode is latched on the first accepted pixel of each frame. Changes mid-frame have no effect until the next frame.
- Input col/row counters wrap at IMG_WIDTH-1 / IMG_HEIGHT-1. Output col/row counters drive m_sof/m_eol.
- Default border handling is replicate/clamp: out-of-image taps take the nearest in-image pixel.
- FSM:
  - FILL: s_ready=1, no output. Accepts the first IMG_WIDTH+1 pixels of the frame, then goes to RUN.
  - RUN: each accepted input produces output pixel (r,c) once input (r+1,c+1) has been accepted. Row/column indices clamp at the edges.
  - Acceptance of input (IMG_HEIGHT-1, IMG_WIDTH-1) moves the FSM to FLUSH.
  - FLUSH: s_ready=0. Emits the remaining IMG_WIDTH+1 outputs using clamped taps. After the last output handshake, returns to FILL.
- Exactly IMG_WIDTH*IMG_HEIGHT outputs are produced per frame, in raster order, with no loss or duplication.
- Reset mid-frame: counters clear, FSM goes to FILL, and m_valid drops. Line-buffer contents are not cleared; FILL overwrites them before use.

## Timing
- Reset values: s_ready=0 during reset, 1 on the first cycle after; m_valid=0, m_pixel=0, m_sof=0, m_eol=0; FSM=FILL.
- The output register is a single stage. In RUN, s_ready = !m_valid || m_ready, so backpressure propagates combinationally.
- In RUN, m_valid rises on the cycle after the handshake that completes a window. Latency is IMG_WIDTH+1 accepted pixels plus 1 clk.
- While m_valid && !m_ready, m_pixel, m_sof and m_eol hold stable.
- In FLUSH, one output is produced per cycle while m_ready=1. The throughput of a full frame is 1 pixel/clk.
- Simultaneous output handshake and new input acceptance in the same cycle is allowed and required.

## Configuration
- CONV3X3_ZERO_PAD_EN defined: out-of-image taps read 0 (zero padding).
- Undefined: replicate/clamp borders as above. Interior pixels are identical in both builds.

## Structure
- Shared package conv_pkg holds:
  - the mode enum (MODE_SHARPEN, MODE_BLUR, MODE_EDGE, MODE_PASS);
  - the FSM state enum;
  - kernel coefficient constants;
  - the saturation function.
- One sub-module, conv_line_buffer: an IMG_WIDTH-deep single-port-per-cycle delay line (read-before-write), instantiated twice.

## Test plan
(All scenarios use IMG_WIDTH=4, IMG_HEIGHT=3.)
- Flat frame, all pixels 100: blur → 12×100; sharpen → 12×100; edge → 12×0. m_sof on the 1st output, m_eol on the 4th/8th/12th.
- Impulse 255 at (1,1), others 0, edge mode → out(1,1)=255 (saturated from 2040), all other 11 outputs 0 (negatives clamp).
- Ramp input, m_ready low for 5 cycles mid-RUN → s_ready low for those cycles, m_pixel stable, 12 outputs in order matching the golden model.
- Mode switched 1→0 at pixel 6 → the whole frame is blurred; the next frame is sharpened.
- rst pulsed after 7 input pixels → m_valid=0 next cycle, s_ready=1; the following full frame matches the golden model exactly.
- CONV3X3_ZERO_PAD_EN, flat 100, blur → corners 56, edge-centres 75, interior 100; sharpen → corners 255.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types, kernel coefficients and saturation helper for the 3x3 streaming convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_SHARPEN = 2'd0,
        MODE_BLUR    = 2'd1,
        MODE_EDGE    = 2'd2,
        MODE_PASS    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } state_t;

    typedef logic signed [4:0] coef_t;

    // Row-major 3x3 kernels, index 4 is the centre tap.
    localparam coef_t K_SHARPEN [9] = '{ 5'sd0, -5'sd1,  5'sd0,
                                        -5'sd1,  5'sd5, -5'sd1,
                                         5'sd0, -5'sd1,  5'sd0};
    localparam coef_t K_BLUR    [9] = '{ 5'sd1,  5'sd2,  5'sd1,
                                         5'sd2,  5'sd4,  5'sd2,
                                         5'sd1,  5'sd2,  5'sd1};
    localparam coef_t K_EDGE    [9] = '{-5'sd1, -5'sd1, -5'sd1,
                                        -5'sd1,  5'sd8, -5'sd1,
                                        -5'sd1, -5'sd1, -5'sd1};

    localparam int BLUR_ROUND = 8;
    localparam int BLUR_SHIFT = 4;

    function automatic coef_t kernel_coef(mode_t m, logic [3:0] idx);
        coef_t c;
        case (m)
            MODE_SHARPEN: c = K_SHARPEN[idx];
            MODE_BLUR:    c = K_BLUR[idx];
            MODE_EDGE:    c = K_EDGE[idx];
            default:      c = (idx == 4'd4) ? 5'sd1 : 5'sd0;
        endcase
        return c;
    endfunction

    function automatic int sat_pixel(int v, int max_val);
        if (v < 0) begin
            return 0;
        end
        if (v > max_val) begin
            return max_val;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel-in / pixel-out valid-ready bundle; slave is the engine side, master the source/sink side.
interface conv3x3_stream_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [PIXEL_WIDTH-1:0] s_pixel;
    logic                   m_valid;
    logic                   m_ready;
    logic [PIXEL_WIDTH-1:0] m_pixel;
    logic                   m_sof;
    logic                   m_eol;

    modport slave (
        input  s_valid, s_pixel, m_ready,
        output s_ready, m_valid, m_pixel, m_sof, m_eol
    );

    modport master (
        output s_valid, s_pixel, m_ready,
        input  s_ready, m_valid, m_pixel, m_sof, m_eol
    );
endinterface

// File: rtl/conv_line_buffer.sv
// DEPTH-cycle delay line (advanced by en): DEPTH-1 RAM words plus the registered read port.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int DEPTH       = 640
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [PIXEL_WIDTH-1:0] din,
    output logic [PIXEL_WIDTH-1:0] dout
);
    localparam int MEM_DEPTH = DEPTH - 1;
    localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [PIXEL_WIDTH-1:0] mem [MEM_DEPTH];
    logic [AW-1:0]          ptr_reg;
    logic [PIXEL_WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (en) begin
            ptr_reg <= (ptr_reg == AW'(MEM_DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    // Read-before-write on the same slot; the read register supplies the final delay stage.
    always_ff @(posedge clk) begin
        if (en) begin
            q_reg        <= mem[ptr_reg];
            mem[ptr_reg] <= din;
        end
    end

    assign dout = q_reg;

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with two line buffers, clamped borders by default;
// define CONV3X3_ZERO_PAD_EN to read out-of-image taps as zero instead.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int ACC_WIDTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    conv3x3_stream_if.slave bus
);
    localparam int CW      = $clog2(IMG_WIDTH);
    localparam int RW      = $clog2(IMG_HEIGHT);
    localparam int PIX_MAX = (1 << PIXEL_WIDTH) - 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t                 state_reg, state_next;
    mode_t                  mode_reg;
    logic [CW-1:0]          in_col_reg, out_col_reg;
    logic [RW-1:0]          in_row_reg, out_row_reg;
    logic [PIXEL_WIDTH-1:0] win_reg [3][2];
    logic                   m_valid_reg, m_sof_reg, m_eol_reg;
    logic [PIXEL_WIDTH-1:0] m_pixel_reg;

    logic                   s_ready_c, accept, emit_slot, out_pending, in_last;
    logic                   advance, produce;
    logic                   row_top, row_bot, col_left, col_right;
    logic [PIXEL_WIDTH-1:0] din, lb1_q, lb2_q;
    logic [PIXEL_WIDTH-1:0] col_in [3];
    logic [PIXEL_WIDTH-1:0] raw [3][3];
    logic [PIXEL_WIDTH-1:0] tap [9];
    logic signed [ACC_WIDTH-1:0] acc, result;
    logic [PIXEL_WIDTH-1:0] pixel_next;

    assign emit_slot   = !m_valid_reg || bus.m_ready;
    assign out_pending = (out_col_reg != '0) || (out_row_reg != '0);
    assign in_last     = (in_col_reg == COL_LAST) && (in_row_reg == ROW_LAST);
    assign accept      = bus.s_valid && s_ready_c;
    assign produce     = advance && (state_reg != ST_FILL);
    assign din         = (state_reg == ST_FLUSH) ? '0 : bus.s_pixel;

    always_comb begin
        s_ready_c = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_FILL: s_ready_c = 1'b1;
                ST_RUN:  s_ready_c = emit_slot;
                default: s_ready_c = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        advance    = accept;
        case (state_reg)
            ST_FILL: begin
                if (accept && (in_row_reg == RW'(1)) && (in_col_reg == '0)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && in_last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Keep the window moving on dummy pixels; clamping hides them.
                advance = out_pending && emit_slot && !rst;
                if (!out_pending && emit_slot) begin
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    conv_line_buffer #(.PIXEL_WIDTH(PIXEL_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk(clk), .rst(rst), .en(advance), .din(din),   .dout(lb1_q)
    );
    conv_line_buffer #(.PIXEL_WIDTH(PIXEL_WIDTH), .DEPTH(IMG_WIDTH)) u_lb2 (
        .clk(clk), .rst(rst), .en(advance), .din(lb1_q), .dout(lb2_q)
    );

    // Newest column: two lines back, one line back, current pixel.
    assign col_in[0] = lb2_q;
    assign col_in[1] = lb1_q;
    assign col_in[2] = din;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            assign raw[gi][0] = win_reg[gi][0];
            assign raw[gi][1] = win_reg[gi][1];
            assign raw[gi][2] = col_in[gi];

            always_ff @(posedge clk) begin
                if (advance) begin
                    win_reg[gi][0] <= win_reg[gi][1];
                    win_reg[gi][1] <= col_in[gi];
                end
            end
        end
    endgenerate

    assign row_top   = (out_row_reg == '0);
    assign row_bot   = (out_row_reg == ROW_LAST);
    assign col_left  = (out_col_reg == '0);
    assign col_right = (out_col_reg == COL_LAST);

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_tap
            localparam int DR = gi / 3;
            localparam int DC = gi % 3;
            logic oob_r, oob_c;
            assign oob_r = ((DR == 0) && row_top)  || ((DR == 2) && row_bot);
            assign oob_c = ((DC == 0) && col_left) || ((DC == 2) && col_right);
`ifdef CONV3X3_ZERO_PAD_EN
            assign tap[gi] = (oob_r || oob_c) ? '0 : raw[DR][DC];
`else
            logic [1:0] r_sel, c_sel;
            assign r_sel   = oob_r ? 2'd1 : 2'(DR);
            assign c_sel   = oob_c ? 2'd1 : 2'(DC);
            assign tap[gi] = raw[r_sel][c_sel];
`endif
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + ACC_WIDTH'(kernel_coef(mode_reg, 4'(i))) * signed'(ACC_WIDTH'(tap[i]));
        end
        result = (mode_reg == MODE_BLUR) ? ((acc + ACC_WIDTH'(BLUR_ROUND)) >>> BLUR_SHIFT) : acc;
        pixel_next = PIXEL_WIDTH'(sat_pixel(int'(result), PIX_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FILL;
            mode_reg    <= MODE_SHARPEN;
            in_col_reg  <= '0;
            in_row_reg  <= '0;
            out_col_reg <= '0;
            out_row_reg <= '0;
            m_valid_reg <= 1'b0;
            m_pixel_reg <= '0;
            m_sof_reg   <= 1'b0;
            m_eol_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                if (in_col_reg == COL_LAST) begin
                    in_col_reg <= '0;
                    in_row_reg <= (in_row_reg == ROW_LAST) ? '0 : in_row_reg + 1'b1;
                end else begin
                    in_col_reg <= in_col_reg + 1'b1;
                end
                if ((in_col_reg == '0) && (in_row_reg == '0)) begin
                    mode_reg <= mode_t'(mode);
                end
            end
            if (produce) begin
                m_valid_reg <= 1'b1;
                m_pixel_reg <= pixel_next;
                m_sof_reg   <= row_top && col_left;
                m_eol_reg   <= col_right;
                if (col_right) begin
                    out_col_reg <= '0;
                    out_row_reg <= row_bot ? '0 : out_row_reg + 1'b1;
                end else begin
                    out_col_reg <= out_col_reg + 1'b1;
                end
            end else if (bus.m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_reg;
    assign bus.m_pixel = m_pixel_reg;
    assign bus.m_sof   = m_sof_reg;
    assign bus.m_eol   = m_eol_reg;

endmodule
